code_lock_ctrl: RTL and testbench



---
 rtl/lock_pkg.sv | 22 ++
 rtl/code_buffer.sv | 64 ++++++
 rtl/code_lock_ctrl.sv | 165 ++++++++++++++++
 tb/tb_code_lock_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared key codes, display char codes and FSM state encodings for the code lock.
package lock_pkg;

   localparam logic [3:0] KeyDigitMax = 4'd9;
   localparam logic [3:0] KeyEnter    = 4'd10;
   localparam logic [3:0] KeyBack     = 4'd11;
   localparam logic [3:0] KeyClear    = 4'd12;
   localparam logic [3:0] KeyChange   = 4'd13;

   localparam logic [4:0] CharBlank = 5'd16;
   localparam logic [4:0] CharDash  = 5'd17;
   localparam logic [4:0] CharErr   = 5'd18;
   localparam logic [4:0] CharOpen  = 5'd19;

   typedef logic [1:0] state_t;

   localparam state_t StEntry   = 2'd0;
   localparam state_t StOpen    = 2'd1;
   localparam state_t StNewcode = 2'd2;
   localparam state_t StLockout = 2'd3;

endpackage

// File: rtl/code_buffer.sv
// Digit entry buffer: stores keyed digits MS-nibble first and compares against the stored code.
module code_buffer
   import lock_pkg::*;
#(
   parameter int unsigned DIGITS = 6,
   localparam int unsigned CW = $clog2(DIGITS + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  clr_i,
   input  logic                  edit_i,
   input  logic [3:0]            key_i,
   input  logic [DIGITS*4-1:0]   code_i,
   output logic [DIGITS*4-1:0]   digits_o,
   output logic [DIGITS*4-1:0]   digits_nx_o,
   output logic [CW-1:0]         cnt_nx_o,
   output logic                  full_o,
   output logic                  match_o
);

   localparam logic [CW-1:0] FullCnt = CW'(DIGITS);

   logic [DIGITS*4-1:0] digits_q, digits_d;
   logic [CW-1:0]       cnt_q, cnt_d;

   always_comb begin
      digits_d = digits_q;
      cnt_d    = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (edit_i) begin
         if (key_i <= KeyDigitMax) begin
            if (cnt_q != FullCnt) begin
               // Entry position p lands in nibble DIGITS-1-p so the first digit is the MS nibble
               for (int i = 0; i < DIGITS; i++) begin
                  if (CW'(i) == cnt_q) digits_d[(DIGITS-1-i)*4 +: 4] = key_i;
               end
               cnt_d = cnt_q + 1'b1;
            end
         end else if (key_i == KeyBack) begin
            if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
         end else if (key_i == KeyClear) begin
            cnt_d = '0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         digits_q <= '0;
         cnt_q    <= '0;
      end else begin
         digits_q <= digits_d;
         cnt_q    <= cnt_d;
      end
   end

   assign digits_o    = digits_q;
   assign digits_nx_o = digits_d;
   assign cnt_nx_o    = cnt_d;
   assign full_o      = (cnt_q == FullCnt);
   assign match_o     = (digits_q == code_i);

endmodule

// File: rtl/code_lock_ctrl.sv
// Keypad code-lock controller: FSM, retry/lockout and relock timers, registered display bus.
module code_lock_ctrl
   import lock_pkg::*;
#(
   parameter int unsigned       DIGITS   = 6,
   parameter int unsigned       MAX_TRY  = 3,
   parameter int unsigned       LOCK_CYC = 50_000_000,
   parameter int unsigned       OPEN_CYC = 250_000_000,
   parameter logic [DIGITS*4-1:0] DEF_CODE = 24'h123456
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [3:0]          key_num,
   input  logic                key_vld,
   output logic [DIGITS*5-1:0] seg_dout,
   output logic [DIGITS-1:0]   seg_dout_vld,
   output logic                unlocked,
   output logic                alarm
);

   localparam int unsigned CW = $clog2(DIGITS + 1);
   localparam int unsigned FW = (MAX_TRY > 1) ? $clog2(MAX_TRY + 1) : 1;
   localparam int unsigned OW = (OPEN_CYC > 1) ? $clog2(OPEN_CYC) : 1;
   localparam int unsigned LW = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;

   localparam logic [FW-1:0] FailLast = FW'(MAX_TRY - 1);
   localparam logic [OW-1:0] OpenLast = OW'(OPEN_CYC - 1);
   localparam logic [LW-1:0] LockLast = LW'(LOCK_CYC - 1);

   state_t                state_q, state_d;
   logic [FW-1:0]         fail_q, fail_d;
   logic [DIGITS*4-1:0]   code_q, code_d;
   logic [OW-1:0]         otmr_q, otmr_d;
   logic [LW-1:0]         ltmr_q, ltmr_d;
   logic [DIGITS*5-1:0]   seg_q, seg_d;
   logic [DIGITS-1:0]     vld_q, vld_d;
   logic                  unl_q, unl_d;
   logic                  alarm_q, alarm_d;
   logic                  fresh_q;

   logic                  expire, buf_clr, buf_edit, buf_full, buf_match;
   logic [DIGITS*4-1:0]   buf_digits, buf_digits_nx;
   logic [CW-1:0]         buf_cnt_nx;
   logic [4:0]            ch;

   code_buffer #(
      .DIGITS (DIGITS)
   ) u_code_buffer (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .clr_i       (buf_clr),
      .edit_i      (buf_edit),
      .key_i       (key_num),
      .code_i      (code_q),
      .digits_o    (buf_digits),
      .digits_nx_o (buf_digits_nx),
      .cnt_nx_o    (buf_cnt_nx),
      .full_o      (buf_full),
      .match_o     (buf_match)
   );

   always_comb begin
      state_d  = state_q;
      fail_d   = fail_q;
      code_d   = code_q;
      buf_edit = 1'b0;
      buf_clr  = 1'b0;
      expire   = ((state_q == StOpen) && (otmr_q == OpenLast)) ||
                 ((state_q == StLockout) && (ltmr_q == LockLast));
      // A timer expiry wins over a simultaneous key, which is dropped
      if (expire) begin
         state_d = StEntry;
      end else if (key_vld) begin
         case (state_q)
            StEntry: begin
               buf_edit = 1'b1;
               if ((key_num == KeyEnter) && buf_full) begin
                  if (buf_match) begin
                     state_d = StOpen;
                     fail_d  = '0;
                  end else if (fail_q == FailLast) begin
                     state_d = StLockout;
                     fail_d  = '0;
                  end else begin
                     fail_d  = fail_q + 1'b1;
                     buf_clr = 1'b1;
                  end
               end
            end
            StOpen: begin
               if ((key_num == KeyEnter) || (key_num == KeyClear)) state_d = StEntry;
               else if (key_num == KeyChange) state_d = StNewcode;
            end
            StNewcode: begin
               buf_edit = 1'b1;
               if ((key_num == KeyEnter) && buf_full) begin
                  code_d  = buf_digits;
                  state_d = StOpen;
               end else if (key_num == KeyClear) begin
                  state_d = StOpen;
               end
            end
            default: ;
         endcase
      end
      // Every state transition starts the next state with an empty buffer
      if (state_d != state_q) buf_clr = 1'b1;
   end

   always_comb begin
      otmr_d  = ((state_q == StOpen) && (state_d == StOpen)) ? otmr_q + 1'b1 : '0;
      ltmr_d  = ((state_q == StLockout) && (state_d == StLockout)) ? ltmr_q + 1'b1 : '0;
      unl_d   = (state_d == StOpen) || (state_d == StNewcode);
      alarm_d = (state_d == StLockout);
   end

   always_comb begin
      seg_d = '0;
      vld_d = '0;
      ch    = CharBlank;
      for (int i = 0; i < DIGITS; i++) begin
         case (state_d)
            StOpen:    ch = CharOpen;
            StLockout: ch = CharErr;
            StNewcode: ch = (CW'(i) < buf_cnt_nx) ?
                            {1'b0, buf_digits_nx[(DIGITS-1-i)*4 +: 4]} : CharBlank;
            default:   ch = (CW'(i) < buf_cnt_nx) ? CharDash : CharBlank;
         endcase
         seg_d[5*i +: 5] = ch;
         vld_d[i] = fresh_q || (state_d != state_q) || (ch != seg_q[5*i +: 5]);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StEntry;
         fail_q  <= '0;
         code_q  <= DEF_CODE;
         otmr_q  <= '0;
         ltmr_q  <= '0;
         seg_q   <= {DIGITS{CharBlank}};
         vld_q   <= '0;
         unl_q   <= 1'b0;
         alarm_q <= 1'b0;
         fresh_q <= 1'b1;
      end else begin
         state_q <= state_d;
         fail_q  <= fail_d;
         code_q  <= code_d;
         otmr_q  <= otmr_d;
         ltmr_q  <= ltmr_d;
         seg_q   <= seg_d;
         vld_q   <= vld_d;
         unl_q   <= unl_d;
         alarm_q <= alarm_d;
         fresh_q <= 1'b0;
      end
   end

   assign seg_dout     = seg_q;
   assign seg_dout_vld = vld_q;
   assign unlocked     = unl_q;
   assign alarm        = alarm_q;

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Directed bench for code_lock_ctrl with short lockout/relock timers.
module tb_code_lock_ctrl;

   localparam logic [4:0] BL = 5'd16;
   localparam logic [4:0] ER = 5'd18;
   localparam logic [4:0] OP = 5'd19;
   localparam logic [3:0] ENT = 4'd10;
   localparam logic [3:0] BCK = 4'd11;
   localparam logic [3:0] CLR = 4'd12;
   localparam logic [3:0] CHG = 4'd13;

   logic        clk;
   logic        rst_n;
   logic [3:0]  key_num;
   logic        key_vld;
   logic [29:0] seg_dout;
   logic [5:0]  seg_dout_vld;
   logic        unlocked;
   logic        alarm;

   int total = 0;
   int bad   = 0;

   code_lock_ctrl #(
      .DIGITS   (6),
      .MAX_TRY  (3),
      .LOCK_CYC (20),
      .OPEN_CYC (10),
      .DEF_CODE (24'h123456)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .key_num      (key_num),
      .key_vld      (key_vld),
      .seg_dout     (seg_dout),
      .seg_dout_vld (seg_dout_vld),
      .unlocked     (unlocked),
      .alarm        (alarm)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [29:0] fill(input logic [4:0] c);
      return {6{c}};
   endfunction

   function automatic logic [29:0] entry_disp(input int n);
      logic [29:0] s;
      for (int i = 0; i < 6; i++) s[5*i +: 5] = (i < n) ? 5'd17 : 5'd16;
      return s;
   endfunction

   function automatic logic [29:0] nc_disp(input logic [23:0] code, input int n);
      logic [29:0] s;
      logic [3:0]  d;
      for (int i = 0; i < 6; i++) begin
         d = code[(5-i)*4 +: 4];
         s[5*i +: 5] = (i < n) ? {1'b0, d} : 5'd16;
      end
      return s;
   endfunction

   // Key is captured on the posedge between the two negedges; outputs are new on return
   task automatic press(input logic [3:0] k);
      @(negedge clk);
      key_num = k;
      key_vld = 1'b1;
      @(negedge clk);
      key_vld = 1'b0;
   endtask

   task automatic enter_code(input logic [23:0] c);
      for (int i = 0; i < 6; i++) press(c[(5-i)*4 +: 4]);
      press(ENT);
   endtask

   initial begin
      rst_n   = 1'b0;
      key_vld = 1'b0;
      key_num = 4'd0;
      repeat (3) @(negedge clk);
      check("rst_seg", 32'(seg_dout), 32'(fill(BL)));
      check("rst_vld", 32'(seg_dout_vld), 32'h0);
      check("rst_unl", 32'(unlocked), 32'h0);
      check("rst_alarm", 32'(alarm), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      check("refresh_vld", 32'(seg_dout_vld), 32'h3F);
      check("refresh_seg", 32'(seg_dout), 32'(fill(BL)));
      @(negedge clk);
      check("refresh_end", 32'(seg_dout_vld), 32'h0);

      // correct default code
      press(4'd1);
      check("d1_seg", 32'(seg_dout), 32'(entry_disp(1)));
      check("d1_vld", 32'(seg_dout_vld), 32'h01);
      press(4'd2);
      check("d2_vld", 32'(seg_dout_vld), 32'h02);
      press(4'd3);
      press(4'd4);
      press(4'd5);
      press(4'd6);
      check("d6_seg", 32'(seg_dout), 32'(entry_disp(6)));
      check("d6_vld", 32'(seg_dout_vld), 32'h20);
      press(ENT);
      check("open_unl", 32'(unlocked), 32'h1);
      check("open_seg", 32'(seg_dout), 32'(fill(OP)));
      check("open_vld", 32'(seg_dout_vld), 32'h3F);
      @(negedge clk);
      check("open_vld_end", 32'(seg_dout_vld), 32'h0);
      press(ENT);
      check("relock_unl", 32'(unlocked), 32'h0);
      check("relock_seg", 32'(seg_dout), 32'(fill(BL)));

      // editing
      press(4'd1);
      press(4'd2);
      press(BCK);
      check("back1_seg", 32'(seg_dout), 32'(entry_disp(1)));
      check("back1_vld", 32'(seg_dout_vld), 32'h02);
      press(BCK);
      check("back2_vld", 32'(seg_dout_vld), 32'h01);
      press(BCK);
      check("back3_seg", 32'(seg_dout), 32'(entry_disp(0)));
      check("back3_vld", 32'(seg_dout_vld), 32'h00);
      for (int i = 1; i <= 5; i++) press(4'(i));
      press(ENT);
      check("short_ent_vld", 32'(seg_dout_vld), 32'h00);
      check("short_ent_seg", 32'(seg_dout), 32'(entry_disp(5)));
      check("short_ent_unl", 32'(unlocked), 32'h0);
      press(CLR);
      check("clear_seg", 32'(seg_dout), 32'(entry_disp(0)));
      check("clear_vld", 32'(seg_dout_vld), 32'h1F);

      // lockout after three wrong entries (short ENTER above must not count)
      for (int t = 0; t < 3; t++) begin
         for (int i = 0; i < 6; i++) press(4'd0);
         if (t == 0) begin
            press(4'd0);
            check("extra_digit_vld", 32'(seg_dout_vld), 32'h00);
         end
         press(ENT);
         if (t < 2) begin
            check("fail_alarm", 32'(alarm), 32'h0);
            check("fail_seg", 32'(seg_dout), 32'(entry_disp(0)));
            check("fail_vld", 32'(seg_dout_vld), 32'h3F);
         end
      end
      check("lock_alarm", 32'(alarm), 32'h1);
      check("lock_seg", 32'(seg_dout), 32'(fill(ER)));
      check("lock_vld", 32'(seg_dout_vld), 32'h3F);
      press(4'd1);
      check("lock_key_vld", 32'(seg_dout_vld), 32'h00);
      repeat (17) @(negedge clk);
      check("lock_hold", 32'(alarm), 32'h1);
      @(negedge clk);
      check("lock_end_alarm", 32'(alarm), 32'h0);
      check("lock_end_seg", 32'(seg_dout), 32'(fill(BL)));
      check("lock_end_vld", 32'(seg_dout_vld), 32'h3F);

      // code change
      enter_code(24'h123456);
      check("cc_open", 32'(unlocked), 32'h1);
      press(CHG);
      check("nc_unl", 32'(unlocked), 32'h1);
      check("nc_seg", 32'(seg_dout), 32'(fill(BL)));
      check("nc_vld", 32'(seg_dout_vld), 32'h3F);
      press(4'd9);
      press(4'd8);
      press(4'd7);
      check("nc3_seg", 32'(seg_dout), 32'(nc_disp(24'h987654, 3)));
      check("nc3_vld", 32'(seg_dout_vld), 32'h04);
      press(4'd6);
      press(4'd5);
      press(4'd4);
      press(ENT);
      check("nc_store_seg", 32'(seg_dout), 32'(fill(OP)));
      check("nc_store_vld", 32'(seg_dout_vld), 32'h3F);
      press(ENT);
      enter_code(24'h123456);
      check("old_code_rej", 32'(unlocked), 32'h0);
      check("old_code_seg", 32'(seg_dout), 32'(entry_disp(0)));
      enter_code(24'h987654);
      check("new_code_acc", 32'(unlocked), 32'h1);

      // auto-relock
      repeat (9) @(negedge clk);
      check("open_hold", 32'(unlocked), 32'h1);
      @(negedge clk);
      check("auto_relock_unl", 32'(unlocked), 32'h0);
      check("auto_relock_seg", 32'(seg_dout), 32'(fill(BL)));
      check("auto_relock_vld", 32'(seg_dout_vld), 32'h3F);

      // CHANGE on the expiry edge is dropped
      enter_code(24'h987654);
      check("prec_open", 32'(unlocked), 32'h1);
      repeat (9) @(negedge clk);
      key_num = CHG;
      key_vld = 1'b1;
      @(negedge clk);
      key_vld = 1'b0;
      check("prec_unl", 32'(unlocked), 32'h0);
      check("prec_vld", 32'(seg_dout_vld), 32'h3F);
      press(4'd1);
      check("prec_entry", 32'(seg_dout), 32'(entry_disp(1)));
      press(CLR);

      // reset in the middle of a code change
      enter_code(24'h987654);
      press(CHG);
      press(4'd1);
      press(4'd1);
      press(4'd1);
      check("mid_nc_seg", 32'(seg_dout), 32'(nc_disp(24'h111000, 3)));
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst_seg", 32'(seg_dout), 32'(fill(BL)));
      check("mid_rst_vld", 32'(seg_dout_vld), 32'h0);
      check("mid_rst_unl", 32'(unlocked), 32'h0);
      check("mid_rst_alarm", 32'(alarm), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      check("mid_refresh_vld", 32'(seg_dout_vld), 32'h3F);
      enter_code(24'h987654);
      check("mid_new_rej", 32'(unlocked), 32'h0);
      enter_code(24'h123456);
      check("def_code_back", 32'(unlocked), 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
